key_expander: RTL and testbench
===============================

# key_expander

Sequential AES key-schedule engine, parametrised over AES-128/192/256. On a start pulse it loads a cipher key and produces round keys 0..NR, one per valid/ready handshake, at most one key every 4 cycles. It generates one 32-bit schedule word per cycle through a shared SubWord path. It replaces the single-round combinational key step in the cipher datapath, and the round controller consumes its stream.

## Interface
- KEY_BITS, 128: key length; legal values 128, 192, 256. Any other value is an elaboration error. Derived values: NK = KEY_BITS/32 (4/6/8), NR = NK+6 (10/12/14), NW = 4*(NR+1) (44/52/60).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to expand key_in; sampled only in IDLE.
- key_in  in  KEY_BITS  cipher key; word 0 is in the MSBs. Captured on the start edge and not needed afterwards.
- busy  out  1  high from the accepting edge until done.
- rk_valid  out  1  rk_out/rk_idx hold a round key.
- rk_ready  in  1  consumer accepts the round key when rk_valid && rk_ready.
- rk_out  out  128  round key; word 4r in bits [127:96].
- rk_idx  out  4  round number r of rk_out (0..NR).
- done  out  1  one-cycle pulse after round key NR is accepted.

## Operation
- States: IDLE, GEN, DRAIN.
- IDLE, start=1: load window[0..NK-1] ← key_in words, set i←0, go to GEN, set busy=1. Start at any other time is ignored.
- GEN: each unstalled edge emits word w[i] and increments i.
  - i < NK: w[i] = key word i.
  - i mod NK == 0: w[i] = w[i-NK] ^ SubWord(RotWord(w[i-1])) ^ RCON[i/NK - 1].
  - NK==8 and i mod 8 == 4: w[i] = w[i-NK] ^ SubWord(w[i-1]).
  - Otherwise: w[i] = w[i-NK] ^ w[i-1].
- Window: a shift register of the last NK words supplies w[i-NK] (oldest) and w[i-1] (newest).
- Assembly: w[i] with i mod 4 ∈ {0,1,2} goes into assembly slots 0..2. When i mod 4 == 3, rk_out ← {slots0..2, w[i]}, rk_idx ← i/4, rk_valid ← 1.
- Stall: when i mod 4 == 3 and rk_valid && !rk_ready, the word is not emitted and i holds. Words with i mod 4 ≠ 3 always proceed.
- After w[NW-1] is emitted, go to DRAIN. When the final key is accepted: rk_valid←0, done=1 for one cycle, busy←0, return to IDLE.
- rk_valid drops on acceptance unless a new key is loaded on the same edge.
- Reset, asynchronous and at any time including mid-expansion: state IDLE, busy=0, rk_valid=0, done=0, rk_out=0, rk_idx=0, i=0, window cleared. There is no partial output afterwards.

## Timing
- E0 is the start edge. Words w0..w3 are emitted on E1..E4, and rk_valid rises after E4 with rk_idx=0.
- With rk_ready held at 1, key r is valid after edge E(4r+4) for exactly one cycle.
- Final key after E(NW): E44 / E52 / E60. done is high in the cycle after the final acceptance edge.
- Back-pressure adds one cycle per stalled cycle. No key is dropped or duplicated.
- rk_out and rk_idx are stable while rk_valid && !rk_ready.
- The earliest accepted restart is the cycle done is high, when state is IDLE.

## Structure
- Shared package key_pkg: the RCON table as 8-bit constants 01,02,04,08,10,20,40,80,1b,36; a function rot_word; the constants NK/NR/NW as functions of KEY_BITS.
- Sub-module: reuse the existing Sbox (ports a, b), four instances forming one SubWord unit. Its input is muxed between RotWord(w[i-1]) and w[i-1].
- The FSM, the index counter i (6 bits), the window, the assembly register and the output register all live in key_expander.

## Test plan
- AES-128 vector: key 2b7e1516 28aed2a6 abf71588 09cf4f3c, rk_ready=1.
  - rk_idx1 = a0fafe17 88542cb1 23a33939 2a6c7605.
  - rk_idx10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6, valid after E44.
  - done follows in the next cycle.
- AES-192 vector (KEY_BITS=192): key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b.
  - rk_idx12 = e98ba06f 448c773c 8ecc7204 01002202.
  - Exactly 13 keys are produced.
- AES-256 vector (KEY_BITS=256): key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4.
  - rk_idx14 = fe4890d1 e6188d0b 046df344 706c631e.
  - Exercises the i mod 8 == 4 SubWord-only path.
- Back-pressure: random rk_ready at 30% duty.
  - Key sequence is identical to the rk_ready=1 run.
  - rk_out is stable across every stall.
  - Total handshakes = NR+1.
- Start while busy: pulse start with a different key at E10. It must be ignored and the output must match the first key's schedule.
- Async reset mid-run: drop rst_n at E20.
  - All outputs go to 0 immediately.
  - A new start then yields a correct rk_idx0 after E4.

Source files
------------

// File: rtl/key_pkg.sv
// Shared AES key-schedule definitions: FSM states, schedule geometry and the
// round-constant table used by key_expander.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        DRAIN
    } kx_state_t;

    function automatic int nk_of(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic int nw_of(input int key_bits);
        return 4 * (nr_of(key_bits) + 1);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/key_expander_sbox.sv
// AES S-box: multiplicative inverse in GF(2^8) (as a^254) followed by the
// standard affine transform.
module sbox (
    input  logic [7:0] a,
    output logic [7:0] b
);

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] xx;
        p  = 8'h00;
        xx = x;
        for (int k = 0; k < 8; k++) begin
            if (y[k]) p = p ^ xx;
            xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // inv accumulates a^(2+4+...+128) = a^254, which maps 0 to 0 as required
    always_comb begin
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/key_expander.sv
// Sequential AES key schedule: one 32-bit word per cycle through a shared
// SubWord unit, round keys handed out over a valid/ready stream.
module key_expander
    import key_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [127:0]        rk_out,
    output logic [3:0]          rk_idx,
    output logic                done
);

    localparam int NK = nk_of(KEY_BITS);
    localparam int NR = nr_of(KEY_BITS);
    localparam int NW = nw_of(KEY_BITS);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("key_expander: KEY_BITS must be 128, 192 or 256");
    end

    kx_state_t   state;
    logic [5:0]  i;
    logic [2:0]  kpos;
    logic [3:0]  blk;
    logic [31:0] win   [NK];
    logic [31:0] slots [3];

    logic [31:0] w_old;
    logic [31:0] w_new;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] w_i;
    logic        key_slot;
    logic        emit;
    logic        accept;

    assign w_old    = win[0];
    assign w_new    = win[NK-1];
    assign key_slot = (i[1:0] == 2'd3);
    assign accept   = rk_valid && rk_ready;
    // Only the word that completes a round key can be held up by the consumer
    assign emit     = (state == GEN) && !(key_slot && rk_valid && !rk_ready);

    assign sub_in = (kpos == 3'd0) ? rot_word(w_new) : w_new;

    for (genvar bi = 0; bi < 4; bi++) begin : g_subword
        sbox u_sbox (
            .a(sub_in[8*bi +: 8]),
            .b(sub_out[8*bi +: 8])
        );
    end

    // For i < NK the window rotates, so win[0] is always key word i
    always_comb begin
        w_i = w_old ^ w_new;
        if (i < 6'(NK)) begin
            w_i = w_old;
        end else if (kpos == 3'd0) begin
            w_i = w_old ^ sub_out ^ {rcon(blk - 4'd1), 24'h000000};
        end else if (NK == 8 && kpos == 3'd4) begin
            w_i = w_old ^ sub_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            i        <= '0;
            kpos     <= '0;
            blk      <= '0;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            done     <= 1'b0;
            rk_out   <= '0;
            rk_idx   <= '0;
            for (int k = 0; k < NK; k++) win[k] <= '0;
            for (int k = 0; k < 3; k++) slots[k] <= '0;
        end else begin
            done <= 1'b0;

            if (emit && key_slot) begin
                rk_valid <= 1'b1;
            end else if (accept) begin
                rk_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < NK; k++) begin
                            win[k] <= key_in[KEY_BITS-1-32*k -: 32];
                        end
                        i     <= '0;
                        kpos  <= '0;
                        blk   <= '0;
                        busy  <= 1'b1;
                        state <= GEN;
                    end
                end
                GEN: begin
                    if (emit) begin
                        for (int k = 0; k < NK-1; k++) win[k] <= win[k+1];
                        win[NK-1] <= w_i;
                        i <= i + 6'd1;
                        if (kpos == 3'(NK-1)) begin
                            kpos <= '0;
                            blk  <= blk + 4'd1;
                        end else begin
                            kpos <= kpos + 3'd1;
                        end
                        case (i[1:0])
                            2'd0: slots[0] <= w_i;
                            2'd1: slots[1] <= w_i;
                            2'd2: slots[2] <= w_i;
                            default: begin
                                rk_out <= {slots[0], slots[1], slots[2], w_i};
                                rk_idx <= i[5:2];
                            end
                        endcase
                        if (i == 6'(NW-1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_expander.sv
// Scoreboard bench for key_expander at all three key sizes: an independent
// table-driven schedule model feeds per-instance expected-key queues.
module tb_key_expander;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   start;
    logic [2:0]   rk_ready;
    logic [2:0]   busy;
    logic [2:0]   rk_valid;
    logic [2:0]   done;
    logic [127:0] rk_out [3];
    logic [3:0]   rk_idx [3];
    logic [127:0] k128;
    logic [191:0] k192;
    logic [255:0] k256;

    logic [2047:0] sbox_v;
    logic [131:0]  exp_q  [3][$];
    logic [131:0]  held_v [3];
    bit            held_f [3];
    int            hs_cnt [3];
    logic [127:0]  cap    [3][16];
    logic [255:0]  keys   [3];
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    key_expander #(.KEY_BITS(128)) u_dut128 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .key_in(k128), .busy(busy[0]),
        .rk_valid(rk_valid[0]), .rk_ready(rk_ready[0]), .rk_out(rk_out[0]),
        .rk_idx(rk_idx[0]), .done(done[0])
    );
    key_expander #(.KEY_BITS(192)) u_dut192 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .key_in(k192), .busy(busy[1]),
        .rk_valid(rk_valid[1]), .rk_ready(rk_ready[1]), .rk_out(rk_out[1]),
        .rk_idx(rk_idx[1]), .done(done[1])
    );
    key_expander #(.KEY_BITS(256)) u_dut256 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .key_in(k256), .busy(busy[2]),
        .rk_valid(rk_valid[2]), .rk_ready(rk_ready[2]), .rk_out(rk_out[2]),
        .rk_idx(rk_idx[2]), .done(done[2])
    );

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = sbox_v[2047 - 8*int'(w[8*b +: 8]) -: 8];
        return r;
    endfunction

    function automatic logic [7:0] rc_of(input int n);
        logic [7:0] r;
        r = 8'h01;
        for (int j = 0; j < n; j++) r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
        return r;
    endfunction

    function automatic void model_push(input int g, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        int nk, nr;
        nk = 4 + 2*g;
        nr = nk + 6;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rc_of(i/nk - 1), 24'h0};
                else if (nk == 8 && i % nk == 4) t = sub_word(t);
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nr; r++) begin
            exp_q[g].push_back({4'(r), w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
        end
    endfunction

    task automatic set_key(input int g, input logic [255:0] key);
        case (g)
            0:       k128 = key[255:128];
            1:       k192 = key[255:64];
            default: k256 = key;
        endcase
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_mon
        always @(negedge clk) begin
            if (held_f[g] && rst_n) begin
                check($sformatf("stall_hold%0d", g), {rk_valid[g], rk_idx[g], rk_out[g]},
                      {1'b1, held_v[g]});
            end
            held_f[g] = rst_n && rk_valid[g] && !rk_ready[g];
            held_v[g] = {rk_idx[g], rk_out[g]};
            if (rst_n && rk_valid[g] && rk_ready[g]) begin
                hs_cnt[g] = hs_cnt[g] + 1;
                cap[g][rk_idx[g]] = rk_out[g];
                check($sformatf("key_expected%0d", g), 136'(exp_q[g].size() != 0), 136'd1);
                if (exp_q[g].size() != 0) begin
                    check($sformatf("rk%0d_idx%0d", g, rk_idx[g]), {rk_idx[g], rk_out[g]},
                          exp_q[g].pop_front());
                end
            end
        end
    end

    task automatic start_key(input int g, input logic [255:0] key);
        @(posedge clk);
        #1;
        set_key(g, key);
        start[g] = 1'b1;
        model_push(g, key);
        @(posedge clk);
        #1;
        start[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input bit bp, input bit alt,
                             input logic [255:0] alt_key, input int rst_at);
        int n, nr, nw, hs0;
        bit seen;
        nr   = 10 + 2*g;
        nw   = 4*(nr+1);
        hs0  = hs_cnt[g];
        n    = 0;
        seen = 0;
        while (!seen && n < 800) begin
            @(posedge clk);
            n++;
            #1;
            rk_ready[g] = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
            if (alt && n == 9) begin
                set_key(g, alt_key);
                start[g] = 1'b1;
            end
            if (alt && n == 10) start[g] = 1'b0;
            if (rst_at != 0 && n == rst_at) begin
                #1 rst_n = 1'b0;
                #1;
                check("rst_ctrl", {busy[g], rk_valid[g], done[g]}, 3'b000);
                check("rst_rk_out", rk_out[g], 128'h0);
                check("rst_rk_idx", rk_idx[g], 4'h0);
                return;
            end
            @(negedge clk);
            if (!bp) begin
                if (n == 4) check("first_key", {rk_valid[g], rk_idx[g]}, {1'b1, 4'd0});
                if (n == 5) check("valid_one_cycle", rk_valid[g], 1'b0);
                if (n == nw) check("final_key", {rk_valid[g], rk_idx[g]}, {1'b1, 4'(nr)});
            end
            if (done[g]) begin
                seen = 1;
                if (!bp) check("done_time", n, nw + 1);
            end
        end
        check("done_seen", seen, 1'b1);
        check("handshakes", hs_cnt[g] - hs0, nr + 1);
        check("queue_empty", exp_q[g].size(), 0);
        @(negedge clk);
        check("done_pulse", {done[g], busy[g]}, 2'b00);
    endtask

    initial begin
        sbox_v   = SBOX_TBL;
        rst_n    = 1'b0;
        start    = '0;
        rk_ready = '1;
        k128     = '0;
        k192     = '0;
        k256     = '0;
        for (int g = 0; g < 3; g++) begin
            held_f[g] = 0;
            hs_cnt[g] = 0;
        end
        keys[0] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        keys[1] = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        keys[2] = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            check("reset_ctrl", {busy[g], rk_valid[g], done[g]}, 3'b000);
            check("reset_out", {rk_idx[g], rk_out[g]}, 132'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int g = 0; g < 3; g++) begin
            start_key(g, keys[g]);
            wait_done(g, 0, 0, '0, 0);
        end
        check("aes128_rk1", cap[0][1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("aes128_rk10", cap[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("aes192_rk12", cap[1][12], 128'he98ba06f448c773c8ecc720401002202);
        check("aes256_rk14", cap[2][14], 128'hfe4890d1e6188d0b046df344706c631e);

        for (int g = 0; g < 3; g++) begin
            start_key(g, keys[g]);
            wait_done(g, 1, 0, '0, 0);
        end

        start_key(0, keys[0]);
        wait_done(0, 0, 1, keys[2], 0);

        start_key(0, keys[0]);
        wait_done(0, 0, 0, '0, 20);
        exp_q[0].delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        start_key(0, keys[0]);
        wait_done(0, 0, 0, '0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
